// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: control decode, immediate generation,
// WB write-through bypass on register reads, load-use stall and branch-flush bubbles.
module id_ex_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic [31:0]     if_id_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic            id_ex_regwrite,
  output logic            id_ex_memread,
  output logic            id_ex_memwrite,
  output logic            id_ex_memtoreg,
  output logic            id_ex_alusrc,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic [3:0]      id_ex_aluop
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] ImmZero = 3'd0;
  localparam logic [2:0] ImmI    = 3'd1;
  localparam logic [2:0] ImmS    = 3'd2;
  localparam logic [2:0] ImmB    = 3'd3;
  localparam logic [2:0] ImmU    = 3'd4;
  localparam logic [2:0] ImmJ    = 3'd5;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rd_addr;

  assign opcode    = if_id_instr[6:0];
  assign rd_addr   = if_id_instr[11:7];
  assign funct3    = if_id_instr[14:12];
  assign rs1_addr  = if_id_instr[19:15];
  assign rs2_addr  = if_id_instr[24:20];
  assign funct7_b5 = if_id_instr[30];

  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_memtoreg;
  logic       dec_alusrc;
  logic       dec_branch;
  logic       dec_jump;
  logic [3:0] dec_aluop;
  logic [2:0] imm_sel;
  logic       rs1_used;
  logic       rs2_used;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_aluop    = 4'b0000;
    imm_sel      = ImmZero;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    case (opcode)
      OpReg: begin
        dec_regwrite = 1'b1;
        dec_aluop    = {funct7_b5, funct3};
        rs2_used     = 1'b1;
      end
      OpImm: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        imm_sel      = ImmI;
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate bits
        dec_aluop    = {(funct3 == 3'b101) & funct7_b5, funct3};
      end
      OpLoad: begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_alusrc   = 1'b1;
        imm_sel      = ImmI;
      end
      OpStore: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        imm_sel      = ImmS;
        rs2_used     = 1'b1;
      end
      OpBranch: begin
        dec_branch = 1'b1;
        imm_sel    = ImmB;
        dec_aluop  = {1'b0, funct3};
        rs2_used   = 1'b1;
      end
      OpJal: begin
        dec_regwrite = 1'b1;
        dec_jump     = 1'b1;
        imm_sel      = ImmJ;
        rs1_used     = 1'b0;
      end
      OpJalr: begin
        dec_regwrite = 1'b1;
        dec_jump     = 1'b1;
        dec_alusrc   = 1'b1;
        imm_sel      = ImmI;
      end
      OpLui, OpAuipc: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        imm_sel      = ImmU;
        rs1_used     = 1'b0;
      end
      default: ;
    endcase
    if (rd_addr == 5'd0) begin
      dec_regwrite = 1'b0;
    end
  end

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic [XLEN-1:0]    dec_imm;

  assign imm_i = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                  if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign imm_u = {if_id_instr[31:12], 12'b0};
  assign imm_j = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                  if_id_instr[20], if_id_instr[30:21], 1'b0};

  always_comb begin
    dec_imm = '0;
    case (imm_sel)
      ImmI:    dec_imm = XLEN'(imm_i);
      ImmS:    dec_imm = XLEN'(imm_s);
      ImmB:    dec_imm = XLEN'(imm_b);
      ImmU:    dec_imm = XLEN'(imm_u);
      ImmJ:    dec_imm = XLEN'(imm_j);
      default: dec_imm = '0;
    endcase
  end

  // The register file is written at the end of the cycle, so a same-cycle WB write
  // must be forwarded here or ID would latch the stale value.
  logic            bypass1;
  logic            bypass2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  assign bypass1  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1_addr);
  assign bypass2  = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2_addr);
  assign rs1_data = bypass1 ? wb_data : rf_rdata1;
  assign rs2_data = bypass2 ? wb_data : rf_rdata2;

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used && (id_ex_rd == rs1_addr);
  assign rs2_hit = rs2_used && (id_ex_rd == rs2_addr);
  assign stall   = id_ex_valid && id_ex_memread && (id_ex_rd != 5'd0) && if_id_valid &&
                   (rs1_hit || rs2_hit);

  logic bubble;
  assign bubble = ex_flush || stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= 5'd0;
      id_ex_rs2      <= 5'd0;
      id_ex_rd       <= 5'd0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_memtoreg <= 1'b0;
      id_ex_alusrc   <= 1'b0;
      id_ex_branch   <= 1'b0;
      id_ex_jump     <= 1'b0;
      id_ex_aluop    <= 4'b0000;
    end else if (bubble) begin
      // Bubble register indices follow the canonical NOP so EX forwarding never matches
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= NOP_INSTR[19:15];
      id_ex_rs2      <= NOP_INSTR[24:20];
      id_ex_rd       <= NOP_INSTR[11:7];
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_memtoreg <= 1'b0;
      id_ex_alusrc   <= 1'b0;
      id_ex_branch   <= 1'b0;
      id_ex_jump     <= 1'b0;
      id_ex_aluop    <= 4'b0000;
    end else begin
      id_ex_valid    <= if_id_valid;
      id_ex_pc       <= if_id_pc;
      id_ex_rs1_data <= rs1_data;
      id_ex_rs2_data <= rs2_data;
      id_ex_imm      <= dec_imm;
      id_ex_rs1      <= rs1_addr;
      id_ex_rs2      <= rs2_addr;
      id_ex_rd       <= rd_addr;
      id_ex_regwrite <= dec_regwrite & if_id_valid;
      id_ex_memread  <= dec_memread & if_id_valid;
      id_ex_memwrite <= dec_memwrite & if_id_valid;
      id_ex_memtoreg <= dec_memtoreg & if_id_valid;
      id_ex_alusrc   <= dec_alusrc & if_id_valid;
      id_ex_branch   <= dec_branch & if_id_valid;
      id_ex_jump     <= dec_jump & if_id_valid;
      id_ex_aluop    <= if_id_valid ? dec_aluop : 4'b0000;
    end
  end

endmodule
